// File: rtl/intpol2_d4_ctrl_fsm.sv
// ============================================================================
// intpol2_d4_ctrl_fsm
// ----------------------------------------------------------------------------
// Sequencing controller for the IntPol2 D4 interpolator datapath.
//
// A run starts from IDLE on start. The controller first loads the three
// coefficients M0..M2 (LDM). It then repeats the following loop for each input
// sample:
//   - wait for the input FIFO to hold data (WAIT),
//   - pop one sample (RD),
//   - for each of the STEPS interpolation steps:
//       launch the datapath step (CALC),
//       wait for the datapath pipeline (LAT),
//       push the result to the output FIFO once it has room (WR).
// The run ends with a one-cycle done pulse (DONE) after the write that the
// next-state logic flags as the final output (comp_cnt).
//
// Parameters
//   CONFIG_WIDTH : width of the run-length configuration path. It is
//                  informational only and must match the datapath.
//   PIPE_LAT     : cycles from en_sum to a valid datapath result (1..15).
//   STEPS        : interpolation steps per input sample (2 or 4).
//
// Ports
//   clk          in   clock, rising edge
//   rstn         in   asynchronous active-low reset
//   clear        in   synchronous abort; returns to IDLE with all outputs low
//   start        in   begin a run; only sampled in IDLE
//   Empty        in   input FIFO empty
//   Afull        in   output FIFO almost full
//   comp_addr    in   coefficient load complete (from next-state logic)
//   comp_cnt     in   output count reached ilen-1 (from next-state logic)
//   busy         out  high in every state except IDLE (registered)
//   en_M_addr    out  advance coefficient address (LDM and load not complete)
//   Read_Enable  out  pop input FIFO (registered, RD only)
//   en_sum       out  launch datapath step (registered, CALC only)
//   Write_Enable out  push output FIFO (WR and output FIFO not almost full)
//   done         out  end-of-run pulse (registered, DONE only)
//   state        out  current state encoding, for debug
//   step         out  step index within the current sample
// ============================================================================
module intpol2_d4_ctrl_fsm #(
    parameter int CONFIG_WIDTH = 32,
    parameter int PIPE_LAT     = 2,
    parameter int STEPS        = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       clear,
    input  logic       start,
    input  logic       Empty,
    input  logic       Afull,
    input  logic       comp_addr,
    input  logic       comp_cnt,
    output logic       busy,
    output logic       en_M_addr,
    output logic       Read_Enable,
    output logic       en_sum,
    output logic       Write_Enable,
    output logic       done,
    output logic [2:0] state,
    output logic [1:0] step
);

    // ------------------------------------------------------------------------
    // Parameter legality, checked at elaboration time
    // ------------------------------------------------------------------------
    generate
        if ((PIPE_LAT < 32'sd1) || (PIPE_LAT > 32'sd15)) begin : g_bad_pipe_lat
            $error("intpol2_d4_ctrl_fsm: PIPE_LAT must be in 1..15");
        end
        if ((STEPS != 32'sd2) && (STEPS != 32'sd4)) begin : g_bad_steps
            $error("intpol2_d4_ctrl_fsm: STEPS must be 2 or 4");
        end
        if (CONFIG_WIDTH < 32'sd1) begin : g_bad_config_width
            $error("intpol2_d4_ctrl_fsm: CONFIG_WIDTH must be positive");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State encoding (fixed values, the debug port exposes them)
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDM  = 3'd1,
        S_WAIT = 3'd2,
        S_RD   = 3'd3,
        S_CALC = 3'd4,
        S_LAT  = 3'd5,
        S_WR   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    // Index of the last step within one sample.
    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);
    // LAT is entered with PIPE_LAT-1 and leaves when the counter reads zero,
    // so the first WR cycle lands PIPE_LAT+1 cycles after the en_sum cycle.
    localparam logic [3:0] LAT_LOAD  = 4'(PIPE_LAT - 1);

    state_t     r_state;
    logic [3:0] r_lat_cnt;
    logic [1:0] r_step;
    logic       r_busy;
    logic       r_read_enable;
    logic       r_en_sum;
    logic       r_done;

    logic       w_write;
    logic       w_m_addr;

    // ------------------------------------------------------------------------
    // Input-dependent strobes. clear masks both so that an abort in the same
    // cycle never lets a write or an address advance slip through.
    // ------------------------------------------------------------------------
    assign w_write  = (r_state == S_WR)  && !Afull     && !clear;
    assign w_m_addr = (r_state == S_LDM) && !comp_addr && !clear;

    // Controller state, step/latency counters and state-decoded outputs.
    // The decoded outputs are registered from the next state, so each one
    // mirrors the state register exactly and is glitch-free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_lat_cnt     <= 4'd0;
            r_step        <= 2'd0;
            r_busy        <= 1'b0;
            r_read_enable <= 1'b0;
            r_en_sum      <= 1'b0;
            r_done        <= 1'b0;
        end else if (clear) begin
            r_state       <= S_IDLE;
            r_lat_cnt     <= 4'd0;
            r_step        <= 2'd0;
            r_busy        <= 1'b0;
            r_read_enable <= 1'b0;
            r_en_sum      <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // Pulse outputs drop unless the branch below enters their state.
            r_read_enable <= 1'b0;
            r_en_sum      <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LDM;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                S_LDM: begin
                    if (comp_addr) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_LDM;
                    end
                end

                S_WAIT: begin
                    if (!Empty) begin
                        r_state       <= S_RD;
                        r_read_enable <= 1'b1;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end

                S_RD: begin
                    r_state  <= S_CALC;
                    r_en_sum <= 1'b1;
                end

                S_CALC: begin
                    r_state   <= S_LAT;
                    r_lat_cnt <= LAT_LOAD;
                end

                S_LAT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state <= S_WR;
                    end else begin
                        r_state   <= S_LAT;
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end

                S_WR: begin
                    if (Afull) begin
                        // Output FIFO has no room: hold without writing.
                        r_state <= S_WR;
                    end else if (comp_cnt) begin
                        // Final output of the run, even mid-sample.
                        r_state <= S_DONE;
                        r_step  <= 2'd0;
                        r_done  <= 1'b1;
                    end else if (r_step == LAST_STEP) begin
                        r_state <= S_WAIT;
                        r_step  <= 2'd0;
                    end else begin
                        r_state  <= S_CALC;
                        r_step   <= r_step + 2'd1;
                        r_en_sum <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_lat_cnt <= 4'd0;
                    r_step    <= 2'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign busy         = r_busy;
    assign en_M_addr    = w_m_addr;
    assign Read_Enable  = r_read_enable;
    assign en_sum       = r_en_sum;
    assign Write_Enable = w_write;
    assign done         = r_done;
    assign state        = r_state;
    assign step         = r_step;

endmodule

// File: tb/tb_intpol2_d4_ctrl_fsm.sv
// ============================================================================
// tb_intpol2_d4_ctrl_fsm
// Directed testbench for intpol2_d4_ctrl_fsm. Two instances: dut_a with the
// default PIPE_LAT=2, dut_b with PIPE_LAT=3. The bench models the coefficient
// address counter (comp_addr after three en_M_addr pulses) and the output
// counter (comp_cnt once ilen-1 writes have been made) for each instance.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well clear of the rising edge.
// ============================================================================
`timescale 1ns/1ps
module tb_intpol2_d4_ctrl_fsm;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LDM  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_CALC = 3'd4;
    localparam logic [2:0] ST_LAT  = 3'd5;
    localparam logic [2:0] ST_WR   = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    logic clk;
    logic rstn;

    // dut_a signals
    logic clear_a, start_a, Empty_a, Afull_a, comp_addr_a, comp_cnt_a;
    logic busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a;
    logic [2:0] state_a;
    logic [1:0] step_a;

    // dut_b signals
    logic clear_b, start_b, Empty_b, Afull_b, comp_addr_b, comp_cnt_b;
    logic busy_b, en_M_addr_b, Read_Enable_b, en_sum_b, Write_Enable_b, done_b;
    logic [2:0] state_b;
    logic [1:0] step_b;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int cnt_m_a, cnt_rd_a, cnt_sum_a, cnt_wr_a, cnt_done_a, step_sum_a, ilen_a;
    int cnt_m_b, cnt_rd_b, cnt_sum_b, cnt_wr_b, cnt_done_b, ilen_b;

    intpol2_d4_ctrl_fsm #(.CONFIG_WIDTH(32), .PIPE_LAT(2), .STEPS(4)) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear_a), .start(start_a),
        .Empty(Empty_a), .Afull(Afull_a), .comp_addr(comp_addr_a), .comp_cnt(comp_cnt_a),
        .busy(busy_a), .en_M_addr(en_M_addr_a), .Read_Enable(Read_Enable_a),
        .en_sum(en_sum_a), .Write_Enable(Write_Enable_a), .done(done_a),
        .state(state_a), .step(step_a)
    );

    intpol2_d4_ctrl_fsm #(.CONFIG_WIDTH(32), .PIPE_LAT(3), .STEPS(4)) dut_b (
        .clk(clk), .rstn(rstn), .clear(clear_b), .start(start_b),
        .Empty(Empty_b), .Afull(Afull_b), .comp_addr(comp_addr_b), .comp_cnt(comp_cnt_b),
        .busy(busy_b), .en_M_addr(en_M_addr_b), .Read_Enable(Read_Enable_b),
        .en_sum(en_sum_b), .Write_Enable(Write_Enable_b), .done(done_b),
        .state(state_b), .step(step_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed loops are all bounded, this only catches a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_counts_a();
        cnt_m_a = 0; cnt_rd_a = 0; cnt_sum_a = 0; cnt_wr_a = 0; cnt_done_a = 0; step_sum_a = 0;
    endtask

    task automatic clear_counts_b();
        cnt_m_b = 0; cnt_rd_b = 0; cnt_sum_b = 0; cnt_wr_b = 0; cnt_done_b = 0;
    endtask

    // One clock cycle. Called just after a falling edge with the test inputs
    // already applied; drives the modelled next-state inputs, records the
    // pulses of this cycle and returns just after the next falling edge.
    task automatic cycle();
        comp_addr_a = (cnt_m_a == 3);
        comp_cnt_a  = (cnt_wr_a == ilen_a - 1);
        comp_addr_b = (cnt_m_b == 3);
        comp_cnt_b  = (cnt_wr_b == ilen_b - 1);
        #1;
        if (en_M_addr_a)    cnt_m_a++;
        if (Read_Enable_a)  cnt_rd_a++;
        if (en_sum_a)       cnt_sum_a++;
        if (Write_Enable_a) begin cnt_wr_a++; step_sum_a += int'(step_a); end
        if (done_a)         cnt_done_a++;
        if (en_M_addr_b)    cnt_m_b++;
        if (Read_Enable_b)  cnt_rd_b++;
        if (en_sum_b)       cnt_sum_b++;
        if (Write_Enable_b) cnt_wr_b++;
        if (done_b)         cnt_done_b++;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Run dut_a until it shows the requested state (bounded).
    task automatic run_until_a(input logic [2:0] target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (state_a == target) break;
            cycle();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        start_a = 1'b1; start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if ({busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_a: outputs got %b expected 0", {busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a});
        end
        tests_run++;
        if ({busy_b, en_M_addr_b, Read_Enable_b, en_sum_b, Write_Enable_b, done_b, state_b, step_b} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_b: outputs got %b expected 0", {busy_b, en_M_addr_b, Read_Enable_b, en_sum_b, Write_Enable_b, done_b, state_b, step_b});
        end
        start_a = 1'b0; start_b = 1'b0;
        rstn = 1'b1;
        cycle();
        tests_run++;
        if (state_a !== ST_IDLE || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: state %0d busy %0d expected state 0 busy 0", state_a, busy_a);
        end
    endtask

    task automatic test_load();
        clear_counts_a();
        Empty_a = 1'b1;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        tests_run++;
        if (state_a !== ST_LDM || busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_enter_ldm: state %0d busy %0d expected state 1 busy 1", state_a, busy_a);
        end
        run_until_a(ST_WAIT, 20);
        tests_run++;
        if (cnt_m_a != 3) begin
            tests_failed++;
            $display("FAIL load_m_pulses: got %0d expected 3", cnt_m_a);
        end
        tests_run++;
        if (state_a !== ST_WAIT) begin
            tests_failed++;
            $display("FAIL load_state_wait: got %0d expected 2", state_a);
        end
    endtask

    task automatic test_stream();
        int t_sum, t_wr;
        clear_counts_a();
        cnt_m_a = 3;
        ilen_a = 8;
        Empty_a = 1'b0;
        Afull_a = 1'b0;
        t_sum = -1; t_wr = -1;
        for (int i = 0; i < 200; i++) begin
            if (state_a == ST_CALC && t_sum < 0) t_sum = cyc;
            if (state_a == ST_WR && t_wr < 0) t_wr = cyc;
            cycle();
            if (cnt_done_a > 0) break;
        end
        tests_run++;
        if (cnt_rd_a != 2) begin
            tests_failed++;
            $display("FAIL stream_reads: got %0d expected 2", cnt_rd_a);
        end
        tests_run++;
        if (cnt_sum_a != 8) begin
            tests_failed++;
            $display("FAIL stream_en_sum: got %0d expected 8", cnt_sum_a);
        end
        tests_run++;
        if (cnt_wr_a != 8) begin
            tests_failed++;
            $display("FAIL stream_writes: got %0d expected 8", cnt_wr_a);
        end
        tests_run++;
        if (step_sum_a != 12) begin
            tests_failed++;
            $display("FAIL stream_step_sum: got %0d expected 12", step_sum_a);
        end
        tests_run++;
        if (t_wr - t_sum != 3) begin
            tests_failed++;
            $display("FAIL stream_latency: got %0d expected 3", t_wr - t_sum);
        end
        tests_run++;
        if (cnt_done_a != 1 || done_a !== 1'b0 || busy_a !== 1'b0 || state_a !== ST_IDLE || step_a !== 2'd0) begin
            tests_failed++;
            $display("FAIL stream_done_end: done_cnt %0d done %0d busy %0d state %0d step %0d expected 1 0 0 0 0",
                     cnt_done_a, done_a, busy_a, state_a, step_a);
        end
    endtask

    task automatic test_empty_stall();
        clear_counts_a();
        ilen_a = 8;
        Empty_a = 1'b1;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        run_until_a(ST_WAIT, 20);
        for (int i = 0; i < 10; i++) begin
            Empty_a = 1'b1;
            cycle();
        end
        tests_run++;
        if (cnt_rd_a != 0 || cnt_sum_a != 0 || cnt_wr_a != 0 || cnt_done_a != 0 || cnt_m_a != 3) begin
            tests_failed++;
            $display("FAIL empty_no_pulses: rd %0d sum %0d wr %0d done %0d m %0d expected 0 0 0 0 3",
                     cnt_rd_a, cnt_sum_a, cnt_wr_a, cnt_done_a, cnt_m_a);
        end
        tests_run++;
        if (state_a !== ST_WAIT || busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL empty_hold_wait: state %0d busy %0d expected 2 1", state_a, busy_a);
        end
        Empty_a = 1'b0;
        cycle();
        tests_run++;
        if (Read_Enable_a !== 1'b1 || state_a !== ST_RD) begin
            tests_failed++;
            $display("FAIL empty_release_read: Read_Enable %0d state %0d expected 1 3", Read_Enable_a, state_a);
        end
    endtask

    task automatic test_clear_and_reset();
        // clear while waiting out the pipeline latency
        run_until_a(ST_LAT, 10);
        clear_a = 1'b1;
        cycle();
        clear_a = 1'b0;
        #1;
        tests_run++;
        if ({busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a} !== 11'd0) begin
            tests_failed++;
            $display("FAIL clear_in_lat: outputs got %b expected 0", {busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a});
        end
        // clear on a cycle that would otherwise write
        clear_counts_a();
        Empty_a = 1'b0; Afull_a = 1'b0;
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        run_until_a(ST_WR, 30);
        clear_a = 1'b1;
        #1;
        tests_run++;
        if (Write_Enable_a !== 1'b0 || state_a !== ST_WR) begin
            tests_failed++;
            $display("FAIL clear_blocks_write: Write_Enable %0d state %0d expected 0 6", Write_Enable_a, state_a);
        end
        cycle();
        clear_a = 1'b0;
        tests_run++;
        if (state_a !== ST_IDLE || cnt_wr_a != 0) begin
            tests_failed++;
            $display("FAIL clear_wr_idle: state %0d writes %0d expected 0 0", state_a, cnt_wr_a);
        end
        // asynchronous reset while writing
        clear_counts_a();
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        run_until_a(ST_WR, 30);
        #1;
        tests_run++;
        if (Write_Enable_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_pre_write: Write_Enable %0d expected 1", Write_Enable_a);
        end
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a} !== 11'd0) begin
            tests_failed++;
            $display("FAIL rst_async_in_wr: outputs got %b expected 0", {busy_a, en_M_addr_a, Read_Enable_a, en_sum_a, Write_Enable_a, done_a, state_a, step_a});
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_latency_afull();
        int t_sum, t_wr, t_write, stall, wr_before;
        logic [2:0] st;
        clear_counts_b();
        ilen_b = 1;
        Empty_b = 1'b0; Afull_b = 1'b0;
        start_b = 1'b1;
        cycle();
        start_b = 1'b0;
        t_sum = -1; t_wr = -1; t_write = -1; stall = 0;
        for (int i = 0; i < 60; i++) begin
            st = state_b;
            if (st == ST_CALC && t_sum < 0) t_sum = cyc;
            if (st == ST_WR && t_wr < 0) t_wr = cyc;
            // Afull rises during LAT and is held for five WR cycles
            Afull_b = (t_sum >= 0) && (cyc > t_sum) && (stall < 5);
            if (st == ST_WR && Afull_b) stall++;
            wr_before = cnt_wr_b;
            cycle();
            if (cnt_wr_b != wr_before && t_write < 0) t_write = cyc - 1;
            if (cnt_done_b > 0) break;
        end
        Afull_b = 1'b0;
        tests_run++;
        if (t_wr - t_sum != 4) begin
            tests_failed++;
            $display("FAIL lat3_first_wr: got %0d expected 4", t_wr - t_sum);
        end
        tests_run++;
        if (t_write - t_wr != 5) begin
            tests_failed++;
            $display("FAIL afull_stall_cycles: got %0d expected 5", t_write - t_wr);
        end
        tests_run++;
        if (cnt_wr_b != 1 || cnt_sum_b != 1 || cnt_done_b != 1) begin
            tests_failed++;
            $display("FAIL afull_single_write: writes %0d en_sum %0d done %0d expected 1 1 1", cnt_wr_b, cnt_sum_b, cnt_done_b);
        end
        tests_run++;
        if (state_b !== ST_IDLE || busy_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_end_idle: state %0d busy %0d expected 0 0", state_b, busy_b);
        end
    endtask

    task automatic test_back_to_back();
        logic pulsed;
        clear_counts_a();
        ilen_a = 8;
        Empty_a = 1'b0; Afull_a = 1'b0;
        start_a = 1'b1;
        cycle();
        pulsed = 1'b0;
        for (int i = 0; i < 200; i++) begin
            // one stray start pulse in CALC, then start held from DONE onward
            if (state_a == ST_CALC && !pulsed) begin
                start_a = 1'b1;
                pulsed = 1'b1;
            end else begin
                start_a = (state_a == ST_DONE);
            end
            cycle();
            if (cnt_done_a > 0) break;
        end
        tests_run++;
        if (cnt_wr_a != 8 || cnt_sum_a != 8 || cnt_rd_a != 2 || cnt_m_a != 3) begin
            tests_failed++;
            $display("FAIL start_in_calc_ignored: wr %0d sum %0d rd %0d m %0d expected 8 8 2 3",
                     cnt_wr_a, cnt_sum_a, cnt_rd_a, cnt_m_a);
        end
        tests_run++;
        if (state_a !== ST_IDLE || busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle_after_done: state %0d busy %0d expected 0 0", state_a, busy_a);
        end
        start_a = 1'b1;
        cnt_m_a = 0;
        cycle();
        start_a = 1'b0;
        tests_run++;
        if (state_a !== ST_LDM || busy_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart: state %0d busy %0d expected 1 1", state_a, busy_a);
        end
    endtask

    initial begin
        rstn = 1'b0;
        clear_a = 1'b0; start_a = 1'b0; Empty_a = 1'b1; Afull_a = 1'b0;
        comp_addr_a = 1'b0; comp_cnt_a = 1'b0;
        clear_b = 1'b0; start_b = 1'b0; Empty_b = 1'b1; Afull_b = 1'b0;
        comp_addr_b = 1'b0; comp_cnt_b = 1'b0;
        ilen_a = 8; ilen_b = 1;
        clear_counts_a();
        clear_counts_b();

        test_reset();
        test_load();
        test_stream();
        test_empty_stall();
        test_clear_and_reset();
        test_latency_afull();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
